// File: rtl/sched_rr_core.sv
// sched_rr_core: priority task scheduler with per-task state table,
// tick-driven delays and round-robin time slicing at equal priority.
module sched_rr_core #(
    parameter int NTASK_W = 4,
    parameter int PRIO_W  = 3,
    parameter int DLY_W   = 16,
    parameter int SLICE   = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               tick_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [1:0]         cmd_op_in,
    input  logic [NTASK_W-1:0] cmd_id_in,
    input  logic [PRIO_W-1:0]  cmd_prio_in,
    input  logic [DLY_W-1:0]   cmd_delay_in,
    output logic               run_valid_out,
    output logic [NTASK_W-1:0] run_id_out,
    output logic [PRIO_W-1:0]  run_prio_out,
    output logic               switch_out,
    output logic               tick_out
);

    localparam int NT   = 1 << NTASK_W;
    localparam int SC_W = $clog2(SLICE + 1);

    typedef enum logic [1:0] {
        T_FREE,
        T_READY,
        T_DELAYED,
        T_SUSP
    } task_st_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TICK,
        S_RESCHED
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;

    task_st_t           r_tstate [NT];
    logic [PRIO_W-1:0]  r_prio   [NT];
    logic [DLY_W-1:0]   r_dly    [NT];

    logic               r_tick_q;
    logic               r_tick_pend;
    logic [SC_W-1:0]    r_slice_cnt;
    logic               r_slice_exp;

    logic               r_run_valid;
    logic [NTASK_W-1:0] r_run_id;
    logic [PRIO_W-1:0]  r_run_prio;
    logic               r_switch;
    logic               r_tick_out;

    logic               w_tick_rise;
    logic               w_cmd_acc;
    logic               w_yield;

    logic               w_any;
    logic [PRIO_W-1:0]  w_max_prio;
    logic               w_keep;
    logic               w_rr_found;
    logic [NTASK_W-1:0] w_rr_id;
    logic [NTASK_W-1:0] w_idx;
    logic [NTASK_W-1:0] w_win_id;
    logic               w_change;

    assign cmd_ready_out = (r_fsm == S_IDLE);
    assign w_cmd_acc     = cmd_valid_in & cmd_ready_out;
    assign w_tick_rise   = tick_in & ~r_tick_q;

    // A zero-delay "delay" command is a yield on a live task.
    assign w_yield = w_cmd_acc && (cmd_op_in == 2'b10)
                     && (cmd_delay_in == '0)
                     && (r_tstate[cmd_id_in] != T_FREE);

    assign run_valid_out = r_run_valid;
    assign run_id_out    = r_run_id;
    assign run_prio_out  = r_run_prio;
    assign switch_out    = r_switch;
    assign tick_out      = r_tick_out;

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state: commands beat ticks; pending ticks run after RESCHED
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    w_fsm_nxt = S_RESCHED;
                end else if (w_tick_rise || r_tick_pend) begin
                    w_fsm_nxt = S_TICK;
                end
            end
            S_TICK: begin
                w_fsm_nxt = S_RESCHED;
            end
            S_RESCHED: begin
                if (r_tick_pend || w_tick_rise) begin
                    w_fsm_nxt = S_TICK;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // Tick edge detect and single-deep pending latch
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tick_q    <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_tick_q <= tick_in;
            if (w_fsm_nxt == S_TICK && r_fsm != S_TICK) begin
                r_tick_pend <= 1'b0;
            end else if (w_tick_rise
                         && (r_fsm != S_IDLE || w_cmd_acc)) begin
                r_tick_pend <= 1'b1;
            end
        end
    end

    // Task table: command updates in IDLE, delay countdown in TICK
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NT; i++) begin
                r_tstate[i] <= T_FREE;
                r_prio[i]   <= '0;
                r_dly[i]    <= '0;
            end
        end else if (w_cmd_acc) begin
            case (cmd_op_in)
                2'b00: begin
                    r_tstate[cmd_id_in] <= T_READY;
                    r_prio[cmd_id_in]   <= cmd_prio_in;
                    r_dly[cmd_id_in]    <= '0;
                end
                2'b01: begin
                    if (r_tstate[cmd_id_in] == T_READY
                        || r_tstate[cmd_id_in] == T_DELAYED) begin
                        r_tstate[cmd_id_in] <= T_SUSP;
                    end
                end
                2'b10: begin
                    if (r_tstate[cmd_id_in] != T_FREE
                        && cmd_delay_in != '0) begin
                        r_tstate[cmd_id_in] <= T_DELAYED;
                        r_dly[cmd_id_in]    <= cmd_delay_in;
                    end
                end
                default: begin
                    r_tstate[cmd_id_in] <= T_FREE;
                end
            endcase
        end else if (r_fsm == S_TICK) begin
            for (int i = 0; i < NT; i++) begin
                if (r_tstate[i] == T_DELAYED) begin
                    if (r_dly[i] != '0) begin
                        r_dly[i] <= r_dly[i] - 1'b1;
                    end
                    if (r_dly[i] == DLY_W'(1)) begin
                        r_tstate[i] <= T_READY;
                    end
                end
            end
        end
    end

    // Winner: highest ready priority, then keep current or rotate forward
    always_comb begin
        w_any      = 1'b0;
        w_max_prio = '0;
        w_rr_found = 1'b0;
        w_rr_id    = r_run_id;
        w_idx      = r_run_id;
        for (int i = 0; i < NT; i++) begin
            if (r_tstate[i] == T_READY) begin
                w_any = 1'b1;
                if (r_prio[i] > w_max_prio) begin
                    w_max_prio = r_prio[i];
                end
            end
        end
        w_keep = r_run_valid
                 && (r_tstate[r_run_id] == T_READY)
                 && (r_prio[r_run_id] == w_max_prio)
                 && !r_slice_exp;
        // k == NT wraps back to the current id, so it is picked last
        for (int k = 1; k <= NT; k++) begin
            w_idx = r_run_id + NTASK_W'(k);
            if (!w_rr_found
                && r_tstate[w_idx] == T_READY
                && r_prio[w_idx] == w_max_prio) begin
                w_rr_found = 1'b1;
                w_rr_id    = w_idx;
            end
        end
        w_win_id = w_keep ? r_run_id : w_rr_id;
        w_change = (w_any != r_run_valid)
                   || (w_any && (w_win_id != r_run_id));
    end

    // Time-slice accounting; yield forces expiry of the current slice
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_slice_cnt <= '0;
            r_slice_exp <= 1'b0;
        end else if (w_yield) begin
            r_slice_exp <= 1'b1;
        end else if (r_fsm == S_TICK) begin
            if (r_run_valid && r_tstate[r_run_id] == T_READY) begin
                if (r_slice_cnt == SC_W'(SLICE - 1)) begin
                    r_slice_cnt <= '0;
                    r_slice_exp <= 1'b1;
                end else begin
                    r_slice_cnt <= r_slice_cnt + 1'b1;
                end
            end
        end else if (r_fsm == S_RESCHED) begin
            r_slice_exp <= 1'b0;
            if (w_change) begin
                r_slice_cnt <= '0;
            end
        end
    end

    // Run outputs and one-cycle switch/tick pulses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run_valid <= 1'b0;
            r_run_id    <= '0;
            r_run_prio  <= '0;
            r_switch    <= 1'b0;
            r_tick_out  <= 1'b0;
        end else begin
            r_switch   <= 1'b0;
            r_tick_out <= (r_fsm == S_TICK);
            if (r_fsm == S_RESCHED) begin
                r_run_valid <= w_any;
                r_switch    <= w_change;
                if (w_any) begin
                    r_run_id   <= w_win_id;
                    r_run_prio <= r_prio[w_win_id];
                end
            end
        end
    end

endmodule
